// File: rtl/loader_pkg.sv
// Shared types and sizing for the boot-time program loader.
// Holds the loader state encoding plus the image geometry and checksum target.
package loader_pkg;

    localparam int ADDR_WIDTH  = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int CHECKSUM_OK = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage : loader_pkg

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port bundle for the program loader.
// master = host side (byte source / RAM observer), slave = the loader itself.
interface program_loader_if;
    import loader_pkg::*;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_address, ram_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_address, ram_data
    );

endinterface : program_loader_if

// File: rtl/program_loader.sv
// Boot loader: streams DEPTH bytes into RAM, verifies a trailing checksum byte,
// and keeps the CPU in reset until an image has verified.
module program_loader
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    program_loader_if.slave     bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] sum_next;

    assign busy     = (state_q == LOAD) || (state_q == CHECK);
    assign accept   = bus.in_valid && busy;
    // Running sum including the byte on the bus; in CHECK this is sum + checksum.
    assign sum_next = sum_q + bus.in_data;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = count_q;
                    ram_data_d = bus.in_data;
                    sum_d      = sum_next;
                    count_d    = count_q + 1'b1;
                    if (count_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (sum_next == DATA_WIDTH'(CHECKSUM_OK)) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign bus.in_ready    = busy;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_address = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign cpu_hold        = (state_q != DONE);
    assign done            = (state_q == DONE);
    assign error           = (state_q == ERROR);

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against an array/queue model
// of the expected RAM image, write sequence and checksum verdict.
module tb_program_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    program_loader_if bus ();

    program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  img     [DEPTH];
    logic [7:0]  mem_exp [DEPTH];
    logic [7:0]  mem_obs [DEPTH];
    logic [11:0] wlog    [$];
    logic [11:0] exp_q   [$];

    // Observe RAM writes mid-cycle, away from the register update edge.
    always @(negedge clk) begin
        if (bus.ram_we) begin
            wlog.push_back({bus.ram_address, bus.ram_data});
            mem_obs[bus.ram_address] = bus.ram_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ram_we",   bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_address, 0);
        check("rst_ram_data", bus.ram_data, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_error",    error, 0);
    endtask

    // One full load: start, DEPTH data bytes with random gaps, then checksum ck.
    // start_at >= 0 re-pulses start after that many bytes (must be ignored).
    task automatic run_image(input logic [7:0] ck, input int max_gap, input int start_at);
        int  s;
        bit  good;
        wlog.delete();
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_ready", bus.in_ready, 1);
        check("start_busy",     busy, 1);
        check("start_cpu_hold", cpu_hold, 1);
        check("start_done",     done, 0);
        check("start_error",    error, 0);
        s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == start_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("restart_ignored", busy, 1);
            end
            send_byte(img[i]);
            exp_q.push_back({4'(i), img[i]});
            mem_exp[i] = img[i];
            s += int'(img[i]);
            repeat ($urandom_range(0, max_gap)) tick();
        end
        send_byte(ck);
        s += int'(ck);
        good = ((s % 256) == 0);
        check("post_ck_in_ready", bus.in_ready, 0);
        check("post_ck_done",     done, good);
        check("post_ck_error",    error, !good);
        check("post_ck_cpu_hold", cpu_hold, !good);
        tick();
        check("write_count", wlog.size(), DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            if (k < wlog.size()) check($sformatf("write_%0d", k), wlog[k], exp_q[k]);
        end
        for (int k = 0; k < DEPTH; k++) check($sformatf("mem_%0d", k), mem_obs[k], mem_exp[k]);
    endtask

    function automatic logic [7:0] good_ck();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < DEPTH; i++) s = s + img[i];
        return 8'h00 - s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            mem_obs[i] = 8'hxx;
            mem_exp[i] = 8'hxx;
        end
        repeat (3) tick();
        check_reset_values();
        reset = 1'b0;
        tick();

        // In IDLE the stream is ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) tick();
        check("idle_no_write", wlog.size(), 0);
        check("idle_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        // Good image of all 0x01, back-to-back.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h01;
        run_image(good_ck(), 0, -1);

        // Stream is ignored in DONE.
        nw = wlog.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("done_no_write", wlog.size(), nw);
        check("done_stays", done, 1);

        // Bad checksum, same image (reload from DONE).
        run_image(good_ck() + 8'h01, 0, -1);

        // Throttled stream 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        run_image(good_ck(), 3, -1);

        // Start pulse during LOAD must not restart.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        run_image(good_ck(), 1, 3);

        // Reset after the 5th accepted byte.
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            img[i] = 8'h30 + 8'(i);
            send_byte(img[i]);
        end
        tick();
        reset = 1'b1;
        #1;
        check_reset_values();
        nw = wlog.size();
        repeat (3) tick();
        check("rst_no_more_writes", wlog.size(), nw);
        check("rst_partial_count", nw, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) check($sformatf("rst_write_%0d", k), wlog[k], {4'(k), img[k]});
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        run_image(good_ck(), 2, -1);

        // Random images, mixing good and bad checksums.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 0) run_image(good_ck(), 2, -1);
            else run_image(good_ck() + 8'($urandom_range(1, 255)), 2, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_program_loader
